// File: rtl/hk_const_store.sv
// SHA-256 H/K constant store: after reset a 72-entry ROM is copied into a 256x32 RAM,
// then H0..H7 / K0..K63 are read combinationally once RDY is high.
module hk_const_store (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HK_SELECTOR,
  input  logic [2:0]  H_ADDR,
  input  logic [5:0]  K_ADDR,
  output logic [31:0] RAM_DR,
  output logic        RDY
);

  typedef enum logic {COPY, READY} state_t;

  localparam logic [6:0] LAST = 7'd71;

  localparam logic [31:0] HK_ROM [0:71] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state, state_n;
  logic [6:0]  cnt, cnt_n;
  logic        we;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] ram [0:255];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= COPY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we      = 1'b0;
    case (state)
      COPY: begin
        we = 1'b1;
        if (cnt == LAST) state_n = READY;
        else             cnt_n   = cnt + 7'd1;
      end
      READY: ;
      default: state_n = COPY;
    endcase
  end

  // H words land at 0..7, K words at 64..127
  assign wr_addr = (cnt < 7'd8) ? {1'b0, cnt} : ({1'b0, cnt} + 8'd56);

  // RAM is intentionally not reset; RDY gating hides stale contents
  always_ff @(posedge CLK) begin
    if (we && !RST) ram[wr_addr] <= HK_ROM[cnt];
  end

  assign rd_addr = HK_SELECTOR ? {2'b01, K_ADDR} : {5'b0, H_ADDR};
  assign RDY     = (state == READY);
  assign RAM_DR  = RDY ? ram[rd_addr] : 32'h0;

endmodule

// File: tb/tb_hk_const_store.sv
// Scoreboard bench for hk_const_store: stimulus queues expected RAM_DR/RDY, a monitor compares.
module tb_hk_const_store;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HK_SELECTOR = 1'b0;
  logic [2:0]  H_ADDR = '0;
  logic [5:0]  K_ADDR = '0;
  logic [31:0] RAM_DR;
  logic        RDY;

  hk_const_store dut (
    .CLK(CLK), .RST(RST), .HK_SELECTOR(HK_SELECTOR),
    .H_ADDR(H_ADDR), .K_ADDR(K_ADDR), .RAM_DR(RAM_DR), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] H_TAB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    logic [31:0] dr;
    logic        rdy;
    string       nm;
  } exp_t;

  exp_t sb[$];
  event smp;
  int   errs = 0;
  int   checks = 0;

  // Monitor: each sample strobe pops one expectation and compares the live outputs
  initial forever begin
    exp_t e;
    @(smp);
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL sb_underflow: sample with no expectation queued");
    end else begin
      e = sb.pop_front();
      if (RAM_DR !== e.dr || RDY !== e.rdy) begin
        errs++;
        $display("FAIL %s: RAM_DR=%h RDY=%b, required RAM_DR=%h RDY=%b",
                 e.nm, RAM_DR, RDY, e.dr, e.rdy);
      end
    end
  end

  task automatic chk(input logic sel, input logic [2:0] h, input logic [5:0] k,
                     input logic [31:0] dr, input logic rdy, input string nm);
    HK_SELECTOR = sel; H_ADDR = h; K_ADDR = k;
    sb.push_back('{dr, rdy, nm});
    #1 -> smp;
    #1;
  endtask

  // Release reset at a falling edge and count rising edges until RDY must rise
  task automatic copy_run(input string tag);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i <= 72; i++) begin
      @(posedge CLK);
      #1;
      if (i < 72)
        chk(1'($urandom), 3'($urandom), 6'($urandom), 32'h0, 1'b0, $sformatf("%s_copy_e%0d", tag, i));
      else
        chk(1'b0, 3'd0, 6'd0, H_TAB[0], 1'b1, $sformatf("%s_rdy_e72", tag));
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++)
      chk(1'b0, 3'(i), 6'($urandom), H_TAB[i], 1'b1, $sformatf("%s_h%0d", tag, i));
    for (int j = 0; j < 64; j++)
      chk(1'b1, 3'($urandom), 6'(j), K_TAB[j], 1'b1, $sformatf("%s_k%0d", tag, j));
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 chk(1'b0, 3'd0, 6'd0, 32'h0, 1'b0, "reset_state");
    chk(1'b1, 3'd7, 6'd63, 32'h0, 1'b0, "reset_state_k");

    copy_run("c1");
    // Hand-picked spot values
    chk(1'b0, 3'd1, 6'd0, 32'hbb67ae85, 1'b1, "h1");
    chk(1'b0, 3'd7, 6'd0, 32'h5be0cd19, 1'b1, "h7");
    chk(1'b1, 3'd0, 6'd0, 32'h428a2f98, 1'b1, "k0");
    chk(1'b1, 3'd0, 6'd1, 32'h71374491, 1'b1, "k1");
    chk(1'b1, 3'd0, 6'd63, 32'hc67178f2, 1'b1, "k63");
    for (int t = 0; t < 4; t++) begin
      chk(1'b0, 3'd2, 6'd2, 32'h3c6ef372, 1'b1, $sformatf("toggle_h2_%0d", t));
      chk(1'b1, 3'd2, 6'd2, 32'hb5c0fbcf, 1'b1, $sformatf("toggle_k2_%0d", t));
    end
    sweep("s1");

    // Reset in the middle of the copy, between clock edges
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    RST = 1'b0;
    for (int i = 1; i <= 30; i++) @(posedge CLK);
    #2 RST = 1'b1;
    chk(1'b1, 3'd0, 6'd63, 32'h0, 1'b0, "rst_mid_copy");
    @(posedge CLK);
    #1 chk(1'b0, 3'd0, 6'd0, 32'h0, 1'b0, "rst_mid_held");
    copy_run("c2");
    sweep("s2");

    // Reset while READY: outputs must drop without a clock edge
    @(negedge CLK);
    chk(1'b1, 3'd0, 6'd63, 32'hc67178f2, 1'b1, "pre_rst_k63");
    RST = 1'b1;
    chk(1'b1, 3'd0, 6'd63, 32'h0, 1'b0, "rst_ready_async");
    @(posedge CLK);
    #1 chk(1'b0, 3'd0, 6'd0, 32'h0, 1'b0, "rst_ready_held");
    copy_run("c3");
    chk(1'b0, 3'd0, 6'd0, 32'h6a09e667, 1'b1, "re_h0");
    chk(1'b1, 3'd0, 6'd63, 32'hc67178f2, 1'b1, "re_k63");

    #5;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_leftover: %0d expectations never sampled, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
